alu_rs: RTL
===========

Name: alu_rs

Overview:
- ALU reservation station: the receiving end of the dispatcher's ALU issue bundle.
- Stores renamed ALU-class instructions (LUI, AUIPC, JAL, JALR, RI, RR) and snoops both CDB broadcasts to wake up pending operands.
- Issues one ready instruction per cycle to the ALU.
- Reports the root of a free entry back to the tag table, which the dispatcher uses to build ALUtagW.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 32, instruction address width
- NAME_W, 5, architectural register name width
- OP_W, 6, opcode width
- TAG_W, 4, full tag width (MSB = prefix, low ROOT_W bits = root)
- ROOT_W, 3, entry index width; entries = 2**ROOT_W = 8
- TAG_FREE, 4'b0000 (codebase tagFree), "no pending producer"; never a live tag

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ALUen  in  1  dispatch valid
- ALUoperandO  in  DATA_W  operand 1 value
- ALUoperandT  in  DATA_W  operand 2 value
- ALUtagO  in  TAG_W  operand 1 producer tag
- ALUtagT  in  TAG_W  operand 2 producer tag
- ALUtagW  in  TAG_W  destination tag; its root selects the entry to write
- ALUnameW  in  NAME_W  destination register name
- ALUop  in  OP_W  opcode
- ALUaddr  in  ADDR_W  instruction address
- enCDBAlu  in  1  ALU CDB broadcast valid
- CDBAluTag  in  TAG_W  ALU CDB tag
- CDBAluData  in  DATA_W  ALU CDB data
- enCDBLS  in  1  LS CDB broadcast valid
- CDBLSTag  in  TAG_W  LS CDB tag
- CDBLSData  in  DATA_W  LS CDB data
- ALUfreeTag  out  ROOT_W  root of the lowest-index free entry
- ALUfull  out  1  no free entry
- ALUworkEn  out  1  issue valid (one-cycle pulse)
- ALUoutO  out  DATA_W  issued operand 1
- ALUoutT  out  DATA_W  issued operand 2
- ALUoutOp  out  OP_W  issued opcode
- ALUoutTagW  out  TAG_W  issued destination tag
- ALUoutNameW  out  NAME_W  issued destination name
- ALUoutAddr  out  ADDR_W  issued address

Behaviour:
- Entry state: valid bit, opO, opT, tagO, tagT, tagW, nameW, op, addr.
- An entry is ready when valid and tagO == TAG_FREE and tagT == TAG_FREE.
- Reset: all valid bits cleared; all issue outputs = 0; ALUworkEn = 0; ALUfreeTag = 0; ALUfull = 0.
- ALUfreeTag and ALUfull are combinational from the registered valid bits only. ALUfreeTag is the lowest-index invalid entry. When full, ALUfull = 1 and ALUfreeTag = 0.
- Dispatch: on a posedge with ALUen = 1, the entry at ALUtagW[ROOT_W-1:0] is written and its valid bit set.
- ALUen while ALUfull = 1 is a protocol violation: the write is dropped and an assertion fires.
- Dispatch bypass: if an incoming ALUtagO/ALUtagT equals a CDB tag broadcast in the same cycle, the CDB data is stored and the tag is stored as TAG_FREE.
  - The ALU CDB has priority over the LS CDB on an identical tag (not expected; prefixes differ).
  - An incoming TAG_FREE never matches.
- Wakeup: on each posedge, every valid entry whose tagO/tagT equals an active CDB tag captures that data and clears the tag to TAG_FREE.
  - Both CDBs may wake different operands of the same entry in the same cycle.
- Issue select: combinational, the lowest-index ready entry, evaluated on registered state.
  - On the posedge, its fields are copied to the out registers, ALUworkEn = 1, and its valid bit is cleared.
  - With no ready entry, ALUworkEn = 0 and the other outputs hold their previous values.
- Latency:
  - Dispatch with both operands ready at edge N → ALUworkEn high after edge N+1.
  - An operand woken at edge N → issue at edge N+1.
  - A dispatch bypassed from the CDB at edge N → issue at edge N+1.
  - There is no same-edge dispatch-to-issue path.
- Freed entry: an entry freed by issue at edge N appears in ALUfreeTag after edge N. The dispatcher can therefore never target an entry that is being issued in the same cycle.
- Simultaneous dispatch, wakeup and issue on different entries all take effect on the same edge.
- Reset asserted mid-operation: all in-flight entries are discarded and ALUworkEn is 0 on the next cycle.
- Throughput: at most one issue per cycle; 8 entries.

Test Plan:
- Reset, then idle → ALUfreeTag = 0, ALUfull = 0, ALUworkEn = 0.
- Dispatch RR with tagO = tagT = TAG_FREE, operands 5 and 7, ALUtagW root 0 → ALUworkEn pulses one cycle after the write edge with ALUoutO = 5, ALUoutT = 7, and the correct op/tagW/nameW/addr. ALUfreeTag reads 1 while the entry is held, then 0 again.
- Dispatch with tagO = 4'b0011 pending; next cycle enCDBAlu with tag 4'b0011 and data 0x1234 → issue on the following edge with ALUoutO = 0x1234.
- Dispatch with tagT = 4'b1010 in the same cycle that enCDBLS broadcasts 4'b1010 with data 0xBEEF → entry stored ready; issues next edge with ALUoutT = 0xBEEF.
- Fill all 8 entries with unready operands → ALUfull = 1. Then broadcast the tag that entry 5 waits on → entry 5 issues, ALUfull drops and ALUfreeTag = 5.
- Entries 2 and 6 both ready in the same cycle → entry 2 issues first, entry 6 on the next edge. Assert rst mid-sequence → ALUworkEn = 0 and all entries free afterwards.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed ALU ops, snoops both CDBs, issues the lowest-index ready entry.
// Latency: dispatch/wakeup at edge N -> issue pulse after edge N+1; no same-edge dispatch-to-issue path.
// Backpressure: ALUfull/ALUfreeTag from registered valid bits; a dispatch while full is dropped.
module alu_rs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 4,
    parameter int ROOT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ALUen,
    input  logic [DATA_W-1:0] ALUoperandO,
    input  logic [DATA_W-1:0] ALUoperandT,
    input  logic [TAG_W-1:0]  ALUtagO,
    input  logic [TAG_W-1:0]  ALUtagT,
    input  logic [TAG_W-1:0]  ALUtagW,
    input  logic [NAME_W-1:0] ALUnameW,
    input  logic [OP_W-1:0]   ALUop,
    input  logic [ADDR_W-1:0] ALUaddr,
    input  logic              enCDBAlu,
    input  logic [TAG_W-1:0]  CDBAluTag,
    input  logic [DATA_W-1:0] CDBAluData,
    input  logic              enCDBLS,
    input  logic [TAG_W-1:0]  CDBLSTag,
    input  logic [DATA_W-1:0] CDBLSData,
    output logic [ROOT_W-1:0] ALUfreeTag,
    output logic              ALUfull,
    output logic              ALUworkEn,
    output logic [DATA_W-1:0] ALUoutO,
    output logic [DATA_W-1:0] ALUoutT,
    output logic [OP_W-1:0]   ALUoutOp,
    output logic [TAG_W-1:0]  ALUoutTagW,
    output logic [NAME_W-1:0] ALUoutNameW,
    output logic [ADDR_W-1:0] ALUoutAddr
);
    localparam int N = 2 ** ROOT_W;
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    typedef struct packed {
        logic [DATA_W-1:0] opo;
        logic [DATA_W-1:0] opt;
        logic [TAG_W-1:0]  tago;
        logic [TAG_W-1:0]  tagt;
        logic [TAG_W-1:0]  tagw;
        logic [NAME_W-1:0] namew;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] dat;
    } operand_t;

    entry_t      ent     [N];
    entry_t      ent_nxt [N];
    logic [N-1:0] vld;
    logic [N-1:0] vld_nxt;
    logic [N-1:0] rdy;
    logic         iss_vld;
    logic [ROOT_W-1:0] iss_sel;
    logic         disp_vld;
    logic [ROOT_W-1:0] disp_sel;
    entry_t       disp_ent;

    // ALU CDB checked last so it wins on an identical tag; TAG_FREE never matches.
    function automatic operand_t snoop(input operand_t cur,
                                       input logic alu_vld, input logic [TAG_W-1:0] alu_tag,
                                       input logic [DATA_W-1:0] alu_dat,
                                       input logic ls_vld, input logic [TAG_W-1:0] ls_tag,
                                       input logic [DATA_W-1:0] ls_dat);
        operand_t res;
        res = cur;
        if (cur.tag != TAG_FREE) begin
            if (ls_vld && cur.tag == ls_tag) begin
                res.tag = TAG_FREE;
                res.dat = ls_dat;
            end
            if (alu_vld && cur.tag == alu_tag) begin
                res.tag = TAG_FREE;
                res.dat = alu_dat;
            end
        end
        return res;
    endfunction

    always_comb begin
        ALUfreeTag = '0;
        ALUfull    = 1'b1;
        iss_vld    = 1'b0;
        iss_sel    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            rdy[i] = vld[i] && ent[i].tago == TAG_FREE && ent[i].tagt == TAG_FREE;
            if (!vld[i]) begin
                ALUfreeTag = ROOT_W'(i);
                ALUfull    = 1'b0;
            end
            if (rdy[i]) begin
                iss_vld = 1'b1;
                iss_sel = ROOT_W'(i);
            end
        end
    end

    always_comb begin
        operand_t o_in;
        operand_t t_in;
        disp_vld = ALUen && !ALUfull;
        disp_sel = ALUtagW[ROOT_W-1:0];
        o_in = snoop('{tag: ALUtagO, dat: ALUoperandO}, enCDBAlu, CDBAluTag, CDBAluData,
                     enCDBLS, CDBLSTag, CDBLSData);
        t_in = snoop('{tag: ALUtagT, dat: ALUoperandT}, enCDBAlu, CDBAluTag, CDBAluData,
                     enCDBLS, CDBLSTag, CDBLSData);
        disp_ent.opo   = o_in.dat;
        disp_ent.tago  = o_in.tag;
        disp_ent.opt   = t_in.dat;
        disp_ent.tagt  = t_in.tag;
        disp_ent.tagw  = ALUtagW;
        disp_ent.namew = ALUnameW;
        disp_ent.op    = ALUop;
        disp_ent.addr  = ALUaddr;
    end

    always_comb begin
        operand_t o_w;
        operand_t t_w;
        for (int i = 0; i < N; i++) begin
            ent_nxt[i] = ent[i];
            vld_nxt[i] = vld[i];
            o_w = snoop('{tag: ent[i].tago, dat: ent[i].opo}, enCDBAlu, CDBAluTag, CDBAluData,
                        enCDBLS, CDBLSTag, CDBLSData);
            t_w = snoop('{tag: ent[i].tagt, dat: ent[i].opt}, enCDBAlu, CDBAluTag, CDBAluData,
                        enCDBLS, CDBLSTag, CDBLSData);
            if (vld[i]) begin
                ent_nxt[i].opo  = o_w.dat;
                ent_nxt[i].tago = o_w.tag;
                ent_nxt[i].opt  = t_w.dat;
                ent_nxt[i].tagt = t_w.tag;
            end
            if (iss_vld && iss_sel == ROOT_W'(i)) begin
                vld_nxt[i] = 1'b0;
            end
            if (disp_vld && disp_sel == ROOT_W'(i)) begin
                ent_nxt[i] = disp_ent;
                vld_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld         <= '0;
            ALUworkEn   <= 1'b0;
            ALUoutO     <= '0;
            ALUoutT     <= '0;
            ALUoutOp    <= '0;
            ALUoutTagW  <= '0;
            ALUoutNameW <= '0;
            ALUoutAddr  <= '0;
        end else begin
            vld       <= vld_nxt;
            ent       <= ent_nxt;
            ALUworkEn <= iss_vld;
            if (iss_vld) begin
                ALUoutO     <= ent[iss_sel].opo;
                ALUoutT     <= ent[iss_sel].opt;
                ALUoutOp    <= ent[iss_sel].op;
                ALUoutTagW  <= ent[iss_sel].tagw;
                ALUoutNameW <= ent[iss_sel].namew;
                ALUoutAddr  <= ent[iss_sel].addr;
            end
        end
    end

    a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (rst) !(ALUen && ALUfull))
        else $error("alu_rs: dispatch while full");

endmodule
